// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: per-channel GPU data-memory request/ack bundle.
//   master (GPU side):    drives read/write valid, addresses and write data; sees ready and read data
//   slave (memory side):  sees the requests; drives read/write ready and read data
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
interface data_mem_responder_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH = `DATA_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic [NUM_CHANNELS-1:0] data_mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] data_mem_read_address;
  logic [NUM_CHANNELS-1:0] data_mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_mem_read_data;
  logic [NUM_CHANNELS-1:0] data_mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] data_mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_mem_write_data;
  logic [NUM_CHANNELS-1:0] data_mem_write_ready;
  modport master (
    output data_mem_read_valid, data_mem_read_address,
    output data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    input  data_mem_read_ready, data_mem_read_data, data_mem_write_ready
  );
  modport slave (
    input  data_mem_read_valid, data_mem_read_address,
    input  data_mem_write_valid, data_mem_write_address, data_mem_write_data,
    output data_mem_read_ready, data_mem_read_data, data_mem_write_ready
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: round-robin arbiter of GPU data-memory channels onto one single-port RAM.
//   clk, reset  : clock and synchronous active-high reset
//   bus (slave) : per-channel read/write requests in, one-cycle acks and read data out
//   oor_error, oor_channel : sticky first out-of-range access flag and its channel,
//                            present only when DMEM_OOR_FLAG_EN is defined
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module data_mem_responder #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH = `DATA_MEMORY_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH = 1024,
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
`ifdef DMEM_OOR_FLAG_EN
  ,
  output logic oor_error,
  output logic [CW-1:0] oor_channel
`endif
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] rr_ptr, gnt_ch, scan;
  logic [NUM_CHANNELS-1:0] inflight, eligible;
  logic gnt, gnt_write, gnt_oor;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [IW-1:0] gnt_idx;

  assign eligible = (bus.data_mem_read_valid | bus.data_mem_write_valid) & ~inflight;

  // Scan from the farthest slot back to rr_ptr so the last hit is the first eligible channel.
  // No grant is issued while reset is sampled, so nothing granted then is ever acked or written.
  always_comb begin
    gnt = 1'b0;
    gnt_ch = '0;
    scan = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      scan = CW'((int'(rr_ptr) + i) % NUM_CHANNELS);
      if (eligible[scan] && !reset) begin
        gnt = 1'b1;
        gnt_ch = scan;
      end
    end
  end

  assign gnt_write = bus.data_mem_write_valid[gnt_ch];
  assign gnt_addr = gnt_write ? bus.data_mem_write_address[gnt_ch] : bus.data_mem_read_address[gnt_ch];
  assign gnt_idx = gnt_addr[IW-1:0];
  assign gnt_oor = |(gnt_addr >> IW);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      inflight <= '0;
      bus.data_mem_read_ready <= '0;
      bus.data_mem_write_ready <= '0;
      bus.data_mem_read_data <= '0;
    end else begin
      // A channel is blocked only during its own ack cycle, while its valid is still up.
      inflight <= gnt ? (NUM_CHANNELS'(1) << gnt_ch) : '0;
      bus.data_mem_read_ready <= '0;
      bus.data_mem_write_ready <= '0;
      if (gnt) begin
        rr_ptr <= (gnt_ch == CW'(NUM_CHANNELS - 1)) ? '0 : gnt_ch + CW'(1);
        if (gnt_write) bus.data_mem_write_ready[gnt_ch] <= 1'b1;
        else begin
          bus.data_mem_read_ready[gnt_ch] <= 1'b1;
          bus.data_mem_read_data[gnt_ch] <= gnt_oor ? '0 : mem[gnt_idx];
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (gnt && gnt_write && !gnt_oor) mem[gnt_idx] <= bus.data_mem_write_data[gnt_ch];

`ifdef DMEM_OOR_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_error <= 1'b0;
      oor_channel <= '0;
    end else if (gnt && gnt_oor && !oor_error) begin
      oor_error <= 1'b1;
      oor_channel <= gnt_ch;
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random stimulus checked cycle by cycle against a behavioural model.
module tb_data_mem_responder;
  localparam int N = 8;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
`ifdef DMEM_OOR_FLAG_EN
  logic oor_error;
  logic [2:0] oor_channel;
`endif

  data_mem_responder #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DMEM_OOR_FLAG_EN
    ,
    .oor_error(oor_error),
    .oor_channel(oor_channel)
`endif
  );

  logic [DW-1:0] mmem [DEPTH];
  bit known [DEPTH];
  int m_rr;
  logic [N-1:0] m_infl;
  logic [N-1:0] exp_rr, exp_wr;
  logic [DW-1:0] exp_rd [N];
  bit exp_ok [N];
  bit exp_rst;
  bit m_oor;
  int m_oor_ch;
  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Decide what the responder must do with the inputs as they stand for the coming edge.
  task automatic model_eval();
    logic [N-1:0] rv, wv, elig;
    int g, a;
    bit oor;
    rv = bus.data_mem_read_valid;
    wv = bus.data_mem_write_valid;
    exp_rr = '0;
    exp_wr = '0;
    if (reset) begin
      exp_rst = 1;
      m_rr = 0;
      m_infl = '0;
      m_oor = 0;
      m_oor_ch = 0;
      for (int c = 0; c < N; c++) begin
        exp_rd[c] = '0;
        exp_ok[c] = 1;
      end
    end else begin
      exp_rst = 0;
      elig = (rv | wv) & ~m_infl;
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
      m_infl = '0;
      if (g >= 0) begin
        m_infl[g] = 1'b1;
        m_rr = (g + 1) % N;
        a = wv[g] ? int'(bus.data_mem_write_address[g]) : int'(bus.data_mem_read_address[g]);
        oor = a >= DEPTH;
        if (wv[g]) begin
          exp_wr[g] = 1'b1;
          if (!oor) begin
            mmem[a] = bus.data_mem_write_data[g];
            known[a] = 1;
          end
        end else begin
          exp_rr[g] = 1'b1;
          exp_rd[g] = oor ? '0 : mmem[a];
          exp_ok[g] = oor || known[a];
        end
        if (oor && !m_oor) begin
          m_oor = 1;
          m_oor_ch = g;
        end
      end
    end
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("read_ready", 64'(bus.data_mem_read_ready), 64'(exp_rr));
    check("write_ready", 64'(bus.data_mem_write_ready), 64'(exp_wr));
    for (int c = 0; c < N; c++)
      if ((exp_rst || exp_rr[c]) && exp_ok[c])
        check($sformatf("read_data[%0d]", c), 64'(bus.data_mem_read_data[c]), 64'(exp_rd[c]));
`ifdef DMEM_OOR_FLAG_EN
    check("oor_error", 64'(oor_error), 64'(m_oor));
    check("oor_channel", 64'(oor_channel), 64'(m_oor_ch));
`endif
    bus.data_mem_read_valid &= ~exp_rr;
    bus.data_mem_write_valid &= ~exp_wr;
  endtask

  task automatic do_read(input int c, input int a, output logic [DW-1:0] d);
    bit got;
    got = 0;
    d = '0;
    bus.data_mem_read_address[c] = AW'(a);
    bus.data_mem_read_valid[c] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (bus.data_mem_read_ready[c]) begin
        got = 1;
        d = bus.data_mem_read_data[c];
      end
    end
    check($sformatf("read ch%0d acked in time", c), 64'(got), 64'd1);
  endtask

  task automatic do_write(input int c, input int a, input logic [DW-1:0] d);
    bit got;
    got = 0;
    bus.data_mem_write_address[c] = AW'(a);
    bus.data_mem_write_data[c] = d;
    bus.data_mem_write_valid[c] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = bus.data_mem_write_ready[c];
    end
    check($sformatf("write ch%0d acked in time", c), 64'(got), 64'd1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 15) == 0) ? AW'(1024 + $urandom_range(0, 3071)) : AW'($urandom_range(0, 63));
  endfunction

  initial begin
    logic [DW-1:0] d;
    int wc, rc, acks;
    bit prev, b2b;
    logic [DW-1:0] rd3;
    bus.data_mem_read_valid = '0;
    bus.data_mem_write_valid = '0;
    bus.data_mem_read_address = '0;
    bus.data_mem_write_address = '0;
    bus.data_mem_write_data = '0;
    step();
    step();
    check("reset ready", 64'({bus.data_mem_read_ready, bus.data_mem_write_ready}), 64'd0);
    reset = 1'b0;

    // Write then read back on ch0
    bus.data_mem_write_address[0] = AW'(5);
    bus.data_mem_write_data[0] = 32'hDEADBEEF;
    bus.data_mem_write_valid[0] = 1'b1;
    step();
    check("t1 write ack", 64'(bus.data_mem_write_ready), 64'h01);
    step();
    check("t1 write ack single", 64'(bus.data_mem_write_ready), 64'h00);
    bus.data_mem_read_address[0] = AW'(5);
    bus.data_mem_read_valid[0] = 1'b1;
    step();
    check("t1 read ack", 64'(bus.data_mem_read_ready), 64'h01);
    check("t1 read data", 64'(bus.data_mem_read_data[0]), 64'hDEADBEEF);

    // Preload, reset (RAM kept), then all channels read at once
    for (int c = 0; c < N; c++) begin
      bus.data_mem_write_address[c] = AW'(100 + c);
      bus.data_mem_write_data[c] = DW'(32'h1000 + c);
    end
    bus.data_mem_write_valid = '1;
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < N; c++) bus.data_mem_read_address[c] = AW'(100 + c);
    bus.data_mem_read_valid = '1;
    for (int c = 0; c < N; c++) begin
      step();
      check($sformatf("t2 ack order %0d", c), 64'(bus.data_mem_read_ready), 64'(1) << c);
      check($sformatf("t2 data %0d", c), 64'(bus.data_mem_read_data[c]), 64'h1000 + 64'(c));
    end
    step();
    check("t2 no second ack", 64'(bus.data_mem_read_ready), 64'h00);

    // Same-channel write and read: write first, read sees it two cycles later
    bus.data_mem_write_address[3] = AW'(9);
    bus.data_mem_write_data[3] = 32'h11;
    bus.data_mem_write_valid[3] = 1'b1;
    bus.data_mem_read_address[3] = AW'(9);
    bus.data_mem_read_valid[3] = 1'b1;
    wc = -1;
    rc = -1;
    rd3 = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (bus.data_mem_write_ready[3] && wc < 0) wc = k;
      if (bus.data_mem_read_ready[3] && rc < 0) begin
        rc = k;
        rd3 = bus.data_mem_read_data[3];
      end
    end
    check("t3 write ack cycle", 64'(wc), 64'd1);
    check("t3 read ack cycle", 64'(rc), 64'd3);
    check("t3 read data", 64'(rd3), 64'h11);

    // Single streaming channel gets one access every two cycles
    acks = 0;
    prev = 0;
    b2b = 0;
    for (int k = 0; k < 12; k++) begin
      if (!bus.data_mem_read_valid[2]) begin
        bus.data_mem_read_address[2] = AW'($urandom_range(0, 63));
        bus.data_mem_read_valid[2] = 1'b1;
      end
      step();
      if (bus.data_mem_read_ready[2]) begin
        acks++;
        if (prev) b2b = 1;
      end
      prev = bus.data_mem_read_ready[2];
    end
    check("t4 ack count", 64'(acks), 64'd6);
    check("t4 back to back", 64'(b2b), 64'd0);
    bus.data_mem_read_valid[2] = 1'b0;
    step();

    // Out-of-range accesses
    do_write(4, 976, 32'h0000ABCD);
`ifdef DMEM_OOR_FLAG_EN
    check("t5 oor clear", 64'(oor_error), 64'd0);
`endif
    do_read(1, 1024, d);
    check("t5 oor read data", 64'(d), 64'd0);
`ifdef DMEM_OOR_FLAG_EN
    check("t5 oor_error set", 64'(oor_error), 64'd1);
    check("t5 oor_channel", 64'(oor_channel), 64'd1);
`endif
    do_write(4, 2000, 32'hFFFF0000);
    do_read(1, 976, d);
    check("t5 ram unchanged", 64'(d), 64'h0000ABCD);
`ifdef DMEM_OOR_FLAG_EN
    check("t5 oor_channel sticky", 64'(oor_channel), 64'd1);
`endif

    // Reset on a would-be grant cycle, then arbitration restarts at ch0
    do_read(5, 100, d);
    bus.data_mem_read_address[6] = AW'(101);
    bus.data_mem_read_valid[6] = 1'b1;
    reset = 1'b1;
    step();
    check("t6 no ack", 64'(bus.data_mem_read_ready), 64'h00);
    check("t6 data cleared", 64'(bus.data_mem_read_data[6]), 64'h0);
    bus.data_mem_read_valid = '0;
    bus.data_mem_write_valid = '0;
    step();
    check("t6 held quiet", 64'({bus.data_mem_read_ready, bus.data_mem_write_ready}), 64'd0);
    reset = 1'b0;
    bus.data_mem_read_address[0] = AW'(100);
    bus.data_mem_read_address[7] = AW'(107);
    bus.data_mem_read_valid[0] = 1'b1;
    bus.data_mem_read_valid[7] = 1'b1;
    step();
    check("t6 first grant ch0", 64'(bus.data_mem_read_ready), 64'h01);
    step();
    check("t6 then ch7", 64'(bus.data_mem_read_ready), 64'h80);
    check("t6 ch7 data", 64'(bus.data_mem_read_data[7]), 64'h1007);

    // Random traffic with occasional resets
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        bus.data_mem_read_valid = '0;
        bus.data_mem_write_valid = '0;
        step();
        reset = 1'b0;
      end else begin
        for (int c = 0; c < N; c++) begin
          if (!bus.data_mem_read_valid[c] && $urandom_range(0, 3) == 0) begin
            bus.data_mem_read_address[c] = rand_addr();
            bus.data_mem_read_valid[c] = 1'b1;
          end
          if (!bus.data_mem_write_valid[c] && $urandom_range(0, 5) == 0) begin
            bus.data_mem_write_address[c] = rand_addr();
            bus.data_mem_write_data[c] = $urandom;
            bus.data_mem_write_valid[c] = 1'b1;
          end
        end
        step();
      end
    end
    for (int k = 0; k < 30; k++) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
